// File: rtl/r4mdc_twiddle_gen.sv
// Radix-4 MDC stage twiddle sequencer: counts accepted samples, emits W^(b*e) for branches 1..3 from a quarter-wave ROM.
// Latency 2 cycles (exponent/address register, then ROM read + sign/swap register); tw_valid mirrors in_valid.
// No backpressure and no buffering; define TWIDDLE_IFFT_EN for conjugate (inverse-FFT) twiddles.
module r4mdc_twiddle_gen #(
    parameter int WL    = 16,
    parameter int N     = 64,
    parameter int STAGE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic [WL-1:0] tw1_r,
    output logic [WL-1:0] tw1_i,
    output logic [WL-1:0] tw2_r,
    output logic [WL-1:0] tw2_i,
    output logic [WL-1:0] tw3_r,
    output logic [WL-1:0] tw3_i,
    output logic          tw_valid,
    output logic          frame_done,
    output logic          busy
);
    localparam int LOGN = $clog2(N);
    localparam int CW   = LOGN - 2;
    localparam int Q    = N / 4;
    localparam int SH   = 2 * STAGE;
    localparam int SPAN = N >> (SH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(Q - 1);
    localparam logic [CW-1:0] POS_MASK = CW'(SPAN - 1);
    localparam logic [CW:0]   QA       = (CW+1)'(Q);

    // Elaboration-time cosine via Taylor series; angle never exceeds pi/2.
    function automatic logic [WL-1:0] cos_q(input int m);
        real x;
        real term;
        real sum;
        int  r;
        x    = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 14; i++) begin
            term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        r = $rtoi(sum * real'(1 << (WL - 1)) + 0.5);
        if (r > (1 << (WL - 1)) - 1) r = (1 << (WL - 1)) - 1;
        if (r < 0) r = 0;
        return WL'(r);
    endfunction

    logic signed [WL-1:0] rom [0:Q];
    for (genvar m = 0; m <= Q; m++) begin : g_rom
        localparam logic [WL-1:0] CV = cos_q(m);
        assign rom[m] = CV;
    end

    typedef enum logic {IDLE, RUN} state_t;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          accept;
    logic          cnt_last;

    assign accept   = (state == RUN) && in_valid;
    assign cnt_last = (cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (!start) state_d = IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // Base exponent e = (c mod L/4) * 4^s; branch multiples wrap modulo N.
    logic [LOGN-1:0] e1, e2, e3;
    assign e1 = {2'b00, cnt & POS_MASK} << SH;
    assign e2 = e1 << 1;
    assign e3 = e1 + e2;

    logic                 v1, last1;
    logic [3:1][LOGN-1:0] k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            k_q   <= '0;
        end else begin
            v1    <= accept;
            last1 <= accept && cnt_last;
            if (accept) k_q <= {e3, e2, e1};
        end
    end

    logic signed [WL-1:0] re_d [1:3];
    logic signed [WL-1:0] im_d [1:3];

    for (genvar b = 1; b <= 3; b++) begin : g_br
        logic [1:0]           q;
        logic [CW:0]          a_cos, a_sin;
        logic signed [WL-1:0] cv, sv, cs, sn;

        assign q     = k_q[b][LOGN-1 -: 2];
        assign a_cos = {1'b0, k_q[b][CW-1:0]};
        assign a_sin = QA - a_cos;
        assign cv    = rom[a_cos];
        assign sv    = rom[a_sin];

        always_comb begin
            cs = cv;
            sn = sv;
            case (q)
                2'd0: begin cs = cv;  sn = sv;  end
                2'd1: begin cs = -sv; sn = cv;  end
                2'd2: begin cs = -cv; sn = -sv; end
                default: begin cs = sv; sn = -cv; end
            endcase
        end

        assign re_d[b] = cs;
`ifdef TWIDDLE_IFFT_EN
        assign im_d[b] = sn;
`else
        assign im_d[b] = -sn;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_valid   <= 1'b0;
            frame_done <= 1'b0;
            tw1_r      <= '0;
            tw1_i      <= '0;
            tw2_r      <= '0;
            tw2_i      <= '0;
            tw3_r      <= '0;
            tw3_i      <= '0;
        end else begin
            tw_valid   <= v1;
            frame_done <= last1;
            if (v1) begin
                tw1_r <= re_d[1];
                tw1_i <= im_d[1];
                tw2_r <= re_d[2];
                tw2_i <= im_d[2];
                tw3_r <= re_d[3];
                tw3_i <= im_d[3];
            end
        end
    end
endmodule

// File: tb/tb_r4mdc_twiddle_gen.sv
// Scoreboard bench for r4mdc_twiddle_gen: STAGE=0 and STAGE=1 instances share stimulus, checked against a $cos/$sin model.
module tb_r4mdc_twiddle_gen;
    localparam int    WL = 16;
    localparam int    N  = 64;
    localparam int    Q  = N / 4;
    localparam real   PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic in_valid;
    logic [1:0][5:0][WL-1:0] tw;
    logic [1:0] vld, fd, bsy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    r4mdc_twiddle_gen #(.WL(WL), .N(N), .STAGE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .tw1_r(tw[0][0]), .tw1_i(tw[0][1]), .tw2_r(tw[0][2]), .tw2_i(tw[0][3]),
        .tw3_r(tw[0][4]), .tw3_i(tw[0][5]),
        .tw_valid(vld[0]), .frame_done(fd[0]), .busy(bsy[0])
    );

    r4mdc_twiddle_gen #(.WL(WL), .N(N), .STAGE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .tw1_r(tw[1][0]), .tw1_i(tw[1][1]), .tw2_r(tw[1][2]), .tw2_i(tw[1][3]),
        .tw3_r(tw[1][4]), .tw3_i(tw[1][5]),
        .tw_valid(vld[1]), .frame_done(fd[1]), .busy(bsy[1])
    );

    typedef struct packed {
        logic [31:0]             due;
        logic [7:0]              idx;
        logic                    last;
        logic [1:0][5:0][WL-1:0] tw;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Round magnitude to Q1.15 and clamp at +32767 so +/-1.0 map to +/-32767.
    function automatic logic [WL-1:0] q15(input real x);
        real mag;
        int  r;
        mag = (x < 0.0) ? -x : x;
        r   = $rtoi(mag * 32768.0 + 0.5);
        if (r > 32767) r = 32767;
        if (x < 0.0) r = -r;
        return 16'(r);
    endfunction

    function automatic logic [5:0][WL-1:0] ref_tw(input int s, input int idx);
        logic [5:0][WL-1:0] res;
        int  span, e, k;
        real ang;
        span = N >> (2 * s + 2);
        e    = (idx % span) * (1 << (2 * s));
        for (int b = 1; b <= 3; b++) begin
            k   = (b * e) % N;
            ang = 2.0 * PI * real'(k) / real'(N);
            res[2*b-2] = q15($cos(ang));
`ifdef TWIDDLE_IFFT_EN
            res[2*b-1] = q15($sin(ang));
`else
            res[2*b-1] = q15(-$sin(ang));
`endif
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (|vld) begin
                if (sb.size() == 0) begin
                    check("unexpected tw_valid", int'(vld), 0);
                end else begin
                    ex = sb.pop_front();
                    check($sformatf("latency idx%0d", ex.idx), cyc, int'(ex.due));
                    for (int s = 0; s < 2; s++) begin
                        check($sformatf("tw_valid s%0d idx%0d", s, ex.idx), int'(vld[s]), 1);
                        check($sformatf("frame_done s%0d idx%0d", s, ex.idx), int'(fd[s]), int'(ex.last));
                        for (int j = 0; j < 6; j++)
                            check($sformatf("tw%0d_%s s%0d idx%0d", j / 2 + 1, (j % 2) ? "i" : "r", s, ex.idx),
                                  int'($signed(tw[s][j])), int'($signed(ex.tw[s][j])));
                    end
                end
            end else begin
                if (|fd) check("frame_done without tw_valid", int'(fd), 0);
                if (sb.size() > 0 && int'(sb[0].due) < cyc) begin
                    check($sformatf("missing tw_valid idx%0d", sb[0].idx), 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        for (int s = 0; s < 2; s++)
            for (int j = 0; j < 6; j++)
                check($sformatf("%s tw[%0d][%0d]", tag, s, j), int'(tw[s][j]), 0);
        check({tag, " tw_valid"}, int'(vld), 0);
        check({tag, " frame_done"}, int'(fd), 0);
        check({tag, " busy"}, int'(bsy), 0);
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy after start", int'(bsy), 3);
    endtask

    task automatic issue(input int idx, input bit st);
        exp_t e;
        e.due   = 32'(cyc + 2);
        e.idx   = 8'(idx);
        e.last  = (idx == Q - 1);
        e.tw[0] = ref_tw(0, idx);
        e.tw[1] = ref_tw(1, idx);
        sb.push_back(e);
        in_valid = 1'b1;
        start    = st;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // mode 0: 3-cycle gap after the 5th sample, 1: random gaps, 2: no gaps
    task automatic run_frame(input bit chain, input int mode);
        bit st;
        int ng;
        for (int idx = 0; idx < Q; idx++) begin
            st = (idx == Q - 1) ? chain : ($urandom_range(0, 3) == 0);
            issue(idx, st);
            if (idx < Q - 1) begin
                ng = (mode == 0) ? ((idx == 4) ? 3 : 0) : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
                repeat (ng) begin
                    start = 1'($urandom_range(0, 1));
                    tick();
                end
                start = 1'b0;
            end
        end
        check("busy after last sample", int'(bsy), chain ? 3 : 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        do_start();
        run_frame(1'b0, 0);

        repeat (3) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("busy idle", int'(bsy), 0);

        do_start();
        run_frame(1'b1, 1);
        run_frame(1'b1, 2);
        run_frame(1'b0, 1);
        repeat (4) tick();

        do_start();
        for (int idx = 0; idx < 7; idx++) issue(idx, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_zero("mid-frame reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();

        do_start();
        run_frame(1'b0, 1);
        repeat (6) tick();
        check("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
